instr_fetcher: RTL and testbench

Front-end fetch stage with a direct-mapped instruction cache.
- Sits directly upstream of the memory controller's instruction-fetch port: issues word fetches on a miss and consumes the returned word.
- Delivers one instruction per cycle (PC, instruction, prediction) to the instruction queue.
- Redirects to a new PC on a global clear (mispredict or flush).

---
 rtl/instr_fetcher_pkg.sv | 23 ++
 rtl/instr_fetcher_if.sv | 43 ++++
 rtl/instr_fetcher_icache.sv | 56 +++++
 rtl/instr_fetcher.sv | 113 +++++++++++
 tb/tb_instr_fetcher.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/instr_fetcher_pkg.sv
// Shared definitions for the instruction fetcher: opcodes, FSM states and
// RISC-V immediate extraction helpers used by static branch prediction.
package instr_fetcher_pkg;

  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;

  typedef enum logic [0:0] {
    StIdle,
    StWaitMem
  } fetch_state_e;

  // J-type immediate, sign-extended to 32 bits
  function automatic logic [31:0] imm_j(input logic [31:0] instr);
    return {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
  endfunction

  // B-type immediate, sign-extended to 32 bits
  function automatic logic [31:0] imm_b(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/instr_fetcher_if.sv
// Fetcher-side bus: instruction-fetch port of the memory controller plus
// the instruction-queue write port. master = fetcher, slave = environment.
interface instr_fetcher_if;

  logic        mem_fetch_enable_out;
  logic [31:0] mem_addr_out;
  logic        mem_result_enable_in;
  logic [31:0] mem_data_in;

  logic        iq_full_in;
  logic        iq_instr_valid_out;
  logic [31:0] iq_instr_out;
  logic [31:0] iq_pc_out;
  logic        iq_pred_taken_out;
  logic [31:0] iq_pred_pc_out;

  modport master (
    output mem_fetch_enable_out,
    output mem_addr_out,
    input  mem_result_enable_in,
    input  mem_data_in,
    input  iq_full_in,
    output iq_instr_valid_out,
    output iq_instr_out,
    output iq_pc_out,
    output iq_pred_taken_out,
    output iq_pred_pc_out
  );

  modport slave (
    input  mem_fetch_enable_out,
    input  mem_addr_out,
    output mem_result_enable_in,
    output mem_data_in,
    output iq_full_in,
    input  iq_instr_valid_out,
    input  iq_instr_out,
    input  iq_pc_out,
    input  iq_pred_taken_out,
    input  iq_pred_pc_out
  );

endinterface

// File: rtl/instr_fetcher_icache.sv
// Direct-mapped, one-word-per-line instruction cache. Addresses are word
// addresses (byte PC >> 2). Read is combinational, write is synchronous.
module instr_fetcher_icache #(
  parameter int unsigned Lines = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] rd_word,
  output logic        hit,
  output logic [31:0] rd_data,
  input  logic        wr_en,
  input  logic [29:0] wr_word,
  input  logic [31:0] wr_data
);

  localparam int unsigned IdxW = $clog2(Lines);
  localparam int unsigned TagW = 30 - IdxW;

  logic [Lines-1:0] valid_q;
  logic [TagW-1:0]  tag_q  [Lines];
  logic [31:0]      data_q [Lines];

  logic [IdxW-1:0] rd_idx;
  logic [TagW-1:0] rd_tag;
  logic [IdxW-1:0] wr_idx;
  logic [TagW-1:0] wr_tag;

  assign rd_idx = rd_word[IdxW-1:0];
  assign rd_tag = rd_word[29:IdxW];
  assign wr_idx = wr_word[IdxW-1:0];
  assign wr_tag = wr_word[29:IdxW];

  // Lookup
  always_comb begin
    hit     = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    rd_data = data_q[rd_idx];
  end

  // Valid bits: cleared on reset, set on fill
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  // Tag and data arrays need no reset; valid gates their use
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end
  end

endmodule

// File: rtl/instr_fetcher.sv
// Fetch stage: looks up pc in the I-cache, issues one instruction per cycle
// on a hit, fetches a word from memory on a miss. A clear redirects pc.
// Optional macro STATIC_BP_EN enables backward-taken / JAL-taken prediction.
module instr_fetcher
  import instr_fetcher_pkg::*;
#(
  parameter int unsigned ICACHE_LINES = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic               clear_flag_in,
  input  logic [31:0]        clear_pc_in,
  instr_fetcher_if.master    bus
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;

  logic         hit;
  logic [31:0]  line_data;
  logic         fill_en;
  logic [31:0]  pred_pc;
  logic         pred_taken;

  // Fill only when the result is actually consumed (not on a clear cycle)
  assign fill_en = rdy && !clear_flag_in && (state_q == StWaitMem) && bus.mem_result_enable_in;

  instr_fetcher_icache #(
    .Lines (ICACHE_LINES)
  ) u_icache (
    .clk     (clk),
    .rst     (rst),
    .rd_word (pc_q[31:2]),
    .hit     (hit),
    .rd_data (line_data),
    .wr_en   (fill_en),
    .wr_word (bus.mem_addr_out[31:2]),
    .wr_data (bus.mem_data_in)
  );

  // Next-PC prediction from the instruction at pc
  always_comb begin
    pred_pc    = pc_q + 32'd4;
    pred_taken = 1'b0;
`ifdef STATIC_BP_EN
    if (line_data[6:0] == OPCODE_JAL) begin
      pred_pc    = pc_q + imm_j(line_data);
      pred_taken = 1'b1;
    end else if ((line_data[6:0] == OPCODE_BRANCH) && imm_b(line_data)[31]) begin
      pred_pc    = pc_q + imm_b(line_data);
      pred_taken = 1'b1;
    end
`endif
  end

  // Fetch FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q                  <= StIdle;
      pc_q                     <= '0;
      bus.mem_fetch_enable_out <= 1'b0;
      bus.mem_addr_out         <= '0;
      bus.iq_instr_valid_out   <= 1'b0;
      bus.iq_instr_out         <= '0;
      bus.iq_pc_out            <= '0;
      bus.iq_pred_taken_out    <= 1'b0;
      bus.iq_pred_pc_out       <= '0;
    end else if (rdy) begin
      if (clear_flag_in) begin
        state_q                  <= StIdle;
        pc_q                     <= {clear_pc_in[31:2], 2'b00};
        bus.mem_fetch_enable_out <= 1'b0;
        bus.mem_addr_out         <= '0;
        bus.iq_instr_valid_out   <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            bus.mem_fetch_enable_out <= 1'b0;
            if (hit) begin
              if (!bus.iq_full_in) begin
                bus.iq_instr_valid_out <= 1'b1;
                bus.iq_instr_out       <= line_data;
                bus.iq_pc_out          <= pc_q;
                bus.iq_pred_taken_out  <= pred_taken;
                bus.iq_pred_pc_out     <= pred_pc;
                pc_q                   <= {pred_pc[31:2], 2'b00};
              end else begin
                bus.iq_instr_valid_out <= 1'b0;
              end
            end else begin
              bus.mem_fetch_enable_out <= 1'b1;
              bus.mem_addr_out         <= pc_q;
              bus.iq_instr_valid_out   <= 1'b0;
              state_q                  <= StWaitMem;
            end
          end
          StWaitMem: begin
            bus.mem_fetch_enable_out <= 1'b0;
            bus.iq_instr_valid_out   <= 1'b0;
            if (bus.mem_result_enable_in) begin
              // Line is written this cycle; the next idle cycle hits
              bus.mem_addr_out <= '0;
              state_q          <= StIdle;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_fetcher.sv
// Directed self-checking bench for instr_fetcher. The memory controller is
// played by hand: each reply pulses mem_result_enable_in 5 cycles after the
// request. Inputs change and outputs are checked 1 time unit after posedge.
module tb_instr_fetcher;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        clear_flag_in;
  logic [31:0] clear_pc_in;

  int unsigned checks = 0;
  int unsigned errors = 0;

  instr_fetcher_if bus ();

  instr_fetcher #(
    .ICACHE_LINES (64)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rdy           (rdy),
    .clear_flag_in (clear_flag_in),
    .clear_pc_in   (clear_pc_in),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Call right after the step where the request pulse was seen
  task automatic mem_reply(input logic [31:0] data);
    repeat (4) step();
    bus.mem_result_enable_in = 1'b1;
    bus.mem_data_in          = data;
    step();
    bus.mem_result_enable_in = 1'b0;
    bus.mem_data_in          = '0;
  endtask

  initial begin
    rst                      = 1'b1;
    rdy                      = 1'b1;
    clear_flag_in            = 1'b0;
    clear_pc_in              = '0;
    bus.mem_result_enable_in = 1'b0;
    bus.mem_data_in          = '0;
    bus.iq_full_in           = 1'b0;
    step();
    step();

    // Reset state
    check("rst_valid", {31'd0, bus.iq_instr_valid_out}, 32'd0);
    check("rst_fetch", {31'd0, bus.mem_fetch_enable_out}, 32'd0);
    check("rst_addr", bus.mem_addr_out, 32'd0);
    check("rst_instr", bus.iq_instr_out, 32'd0);
    check("rst_pc", bus.iq_pc_out, 32'd0);
    check("rst_pred_pc", bus.iq_pred_pc_out, 32'd0);
    rst = 1'b0;

    // Cold start: miss at 0
    step();
    check("cold_req", {31'd0, bus.mem_fetch_enable_out}, 32'd1);
    check("cold_addr", bus.mem_addr_out, 32'd0);
    step();
    check("cold_req_pulse", {31'd0, bus.mem_fetch_enable_out}, 32'd0);
    check("cold_addr_held", bus.mem_addr_out, 32'd0);
    mem_reply(32'h0000_0013);
    check("fill_valid0", {31'd0, bus.iq_instr_valid_out}, 32'd0);
    check("fill_addr0", bus.mem_addr_out, 32'd0);
    step();
    check("cold_valid", {31'd0, bus.iq_instr_valid_out}, 32'd1);
    check("cold_instr", bus.iq_instr_out, 32'h0000_0013);
    check("cold_pc", bus.iq_pc_out, 32'd0);
    check("cold_pred_pc", bus.iq_pred_pc_out, 32'd4);
    check("cold_pred_tk", {31'd0, bus.iq_pred_taken_out}, 32'd0);
    step();
    check("miss4_req", {31'd0, bus.mem_fetch_enable_out}, 32'd1);
    check("miss4_addr", bus.mem_addr_out, 32'd4);

    // Clear back to 0 while waiting: cached hit, no request
    clear_flag_in = 1'b1;
    clear_pc_in   = 32'd0;
    step();
    clear_flag_in = 1'b0;
    check("clr_valid", {31'd0, bus.iq_instr_valid_out}, 32'd0);
    check("clr_addr", bus.mem_addr_out, 32'd0);
    step();
    check("hit_valid", {31'd0, bus.iq_instr_valid_out}, 32'd1);
    check("hit_instr", bus.iq_instr_out, 32'h0000_0013);
    check("hit_noreq", {31'd0, bus.mem_fetch_enable_out}, 32'd0);

    // Redirect to 0 again, then hold iq_full for 3 cycles
    clear_flag_in = 1'b1;
    clear_pc_in   = 32'd0;
    step();
    clear_flag_in  = 1'b0;
    bus.iq_full_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("full_valid", {31'd0, bus.iq_instr_valid_out}, 32'd0);
      check("full_noreq", {31'd0, bus.mem_fetch_enable_out}, 32'd0);
    end
    bus.iq_full_in = 1'b0;
    step();
    check("resume_valid", {31'd0, bus.iq_instr_valid_out}, 32'd1);
    check("resume_pc", bus.iq_pc_out, 32'd0);
    step();
    check("miss4b_req", {31'd0, bus.mem_fetch_enable_out}, 32'd1);
    check("miss4b_addr", bus.mem_addr_out, 32'd4);

    // Clear coinciding with the result pulse: result ignored
    repeat (4) step();
    clear_flag_in            = 1'b1;
    clear_pc_in              = 32'h100;
    bus.mem_result_enable_in = 1'b1;
    bus.mem_data_in          = 32'hDEAD_BEEF;
    step();
    clear_flag_in            = 1'b0;
    bus.mem_result_enable_in = 1'b0;
    check("clrres_valid", {31'd0, bus.iq_instr_valid_out}, 32'd0);
    check("clrres_addr", bus.mem_addr_out, 32'd0);
    step();
    check("req100", {31'd0, bus.mem_fetch_enable_out}, 32'd1);
    check("req100_addr", bus.mem_addr_out, 32'h100);
    mem_reply(32'h0000_0093);
    step();
    check("i100_valid", {31'd0, bus.iq_instr_valid_out}, 32'd1);
    check("i100_instr", bus.iq_instr_out, 32'h0000_0093);
    check("i100_pc", bus.iq_pc_out, 32'h100);

    // rdy low freezes everything
    rdy = 1'b0;
    step();
    step();
    check("rdy_hold_valid", {31'd0, bus.iq_instr_valid_out}, 32'd1);
    check("rdy_hold_pc", bus.iq_pc_out, 32'h100);
    check("rdy_hold_req", {31'd0, bus.mem_fetch_enable_out}, 32'd0);
    rdy = 1'b1;

    // 0x100 evicted line 0: fetching 0 again needs memory
    clear_flag_in = 1'b1;
    clear_pc_in   = 32'd0;
    step();
    clear_flag_in = 1'b0;
    step();
    check("evict_req", {31'd0, bus.mem_fetch_enable_out}, 32'd1);
    check("evict_addr", bus.mem_addr_out, 32'd0);
    mem_reply(32'h0000_0013);
    step();
    check("evict_valid", {31'd0, bus.iq_instr_valid_out}, 32'd1);
    check("evict_pc", bus.iq_pc_out, 32'd0);
    step();
    // Line 4 was never written by the ignored result
    check("nowr4_req", {31'd0, bus.mem_fetch_enable_out}, 32'd1);
    check("nowr4_addr", bus.mem_addr_out, 32'd4);

`ifdef STATIC_BP_EN
    // JAL +16 at 0x8
    clear_flag_in = 1'b1;
    clear_pc_in   = 32'h8;
    step();
    clear_flag_in = 1'b0;
    step();
    check("req8_addr", bus.mem_addr_out, 32'h8);
    mem_reply(32'h0100_006F);
    step();
    check("jal_valid", {31'd0, bus.iq_instr_valid_out}, 32'd1);
    check("jal_taken", {31'd0, bus.iq_pred_taken_out}, 32'd1);
    check("jal_pred_pc", bus.iq_pred_pc_out, 32'h18);
    step();
    check("jal_next_req", {31'd0, bus.mem_fetch_enable_out}, 32'd1);
    check("jal_next_addr", bus.mem_addr_out, 32'h18);

    // BEQ -8 at 0x20
    clear_flag_in = 1'b1;
    clear_pc_in   = 32'h20;
    step();
    clear_flag_in = 1'b0;
    step();
    check("req20_addr", bus.mem_addr_out, 32'h20);
    mem_reply(32'hFE00_0CE3);
    step();
    check("beq_valid", {31'd0, bus.iq_instr_valid_out}, 32'd1);
    check("beq_taken", {31'd0, bus.iq_pred_taken_out}, 32'd1);
    check("beq_pred_pc", bus.iq_pred_pc_out, 32'h18);
    step();
    check("beq_next_addr", bus.mem_addr_out, 32'h18);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
